// File: rtl/branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_btb
// Description : Direct-mapped branch target buffer with 2-bit saturating
//               direction counters, tag check and a saturating mispredict count.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_btb #(
  parameter int ENTRIES = 8,
  parameter int MISS_W  = 16,
  localparam int IDX_W  = $clog2(ENTRIES),
  localparam int TAG_W  = 32 - IDX_W - 2
) (
  input  logic              CLK,
  input  logic              RST,
  // fetch-side lookup
  input  logic [31:0]       pc,
  input  logic              lookup_en,
  output logic              predict,
  output logic [31:0]       br_target_O,
  output logic [IDX_W-1:0]  index_O,
  output logic              hit,
  // execute-side update
  input  logic              update_en,
  input  logic [IDX_W-1:0]  index_update,
  input  logic [TAG_W-1:0]  update_tag,
  input  logic              br_taken,
  input  logic [31:0]       br_target_I,
  input  logic              predicted,
  input  logic              flush_btb,
  output logic [MISS_W-1:0] mispredict_cnt
);

  localparam logic [1:0]        c_ctr_rst   = 2'b01;
  localparam logic [1:0]        c_ctr_alloc = 2'b10;
  localparam logic [MISS_W-1:0] c_miss_max  = '1;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];
  logic [MISS_W-1:0]  r_miss_cnt;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_upd_hit;
  logic               w_upd_ok;
  logic [1:0]         w_ctr_cur;
  logic [1:0]         w_ctr_next;
  logic               w_mispredict;

  // Address bits [1:0] and lookup_en do not influence predictor state.
  logic w_unused;
  assign w_unused = &{1'b0, pc[1:0], lookup_en};

  // ---------------------------------------------------------------- lookup
  assign w_idx       = pc[IDX_W+1:2];
  assign w_tag       = pc[31:IDX_W+2];
  assign hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign predict     = hit && r_ctr[w_idx][1];
  assign br_target_O = r_target[w_idx];
  assign index_O     = w_idx;

  // ---------------------------------------------------------------- update
  assign w_upd_ok   = update_en && !flush_btb;
  assign w_upd_hit  = r_valid[index_update] && (r_tag[index_update] == update_tag);
  assign w_ctr_cur  = r_ctr[index_update];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (!w_upd_hit) begin
      w_ctr_next = c_ctr_alloc;
    end else if (br_taken) begin
      if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'b01;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'b01;
    end
  end

  // A taken branch always (re)writes tag/target/valid: on a hit the tag is
  // unchanged, on a miss this is the allocation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= c_ctr_rst;
      end
    end else if (flush_btb) begin
      r_valid <= '0;
    end else if (w_upd_ok) begin
      if (w_upd_hit || br_taken) begin
        r_ctr[index_update] <= w_ctr_next;
      end
      if (br_taken) begin
        r_valid[index_update]  <= 1'b1;
        r_tag[index_update]    <= update_tag;
        r_target[index_update] <= br_target_I;
      end
    end
  end

  // ------------------------------------------------------ mispredict count
  // Counted regardless of flush: the branch still resolved wrongly.
  assign w_mispredict = update_en && (predicted != br_taken);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_miss_cnt <= '0;
    end else if (w_mispredict && (r_miss_cnt != c_miss_max)) begin
      r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign mispredict_cnt = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor_btb
// Description : Directed self-checking bench for branch_predictor_btb
//               (ENTRIES=8, MISS_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        lookup_en;
  logic        predict;
  logic [31:0] br_target_o;
  logic [2:0]  index_o;
  logic        hit;
  logic        update_en;
  logic [2:0]  index_update;
  logic [26:0] update_tag;
  logic        br_taken;
  logic [31:0] br_target_i;
  logic        predicted;
  logic        flush_btb;
  logic [3:0]  mispredict_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predictor_btb #(.ENTRIES(8), .MISS_W(4)) dut (
    .CLK            (clk),
    .RST            (rst),
    .pc             (pc),
    .lookup_en      (lookup_en),
    .predict        (predict),
    .br_target_O    (br_target_o),
    .index_O        (index_o),
    .hit            (hit),
    .update_en      (update_en),
    .index_update   (index_update),
    .update_tag     (update_tag),
    .br_taken       (br_taken),
    .br_target_I    (br_target_i),
    .predicted      (predicted),
    .flush_btb      (flush_btb),
    .mispredict_cnt (mispredict_cnt)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] a);
    pc = a;
    #1;
  endtask

  // Drive one resolving branch for address a; applied at the next edge.
  task automatic upd(input logic [31:0] a, input logic tk, input logic [31:0] tgt, input logic pr);
    update_en    = 1'b1;
    index_update = a[4:2];
    update_tag   = a[31:5];
    br_taken     = tk;
    br_target_i  = tgt;
    predicted    = pr;
  endtask

  task automatic idle();
    update_en = 1'b0;
    flush_btb = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc = 32'h0; lookup_en = 1'b1;
    update_en = 1'b0; index_update = '0; update_tag = '0;
    br_taken = 1'b0; br_target_i = '0; predicted = 1'b0; flush_btb = 1'b0;

    // Reset
    step(); step();
    rst = 1'b0;
    look(32'h40);
    check("rst_hit",     hit, 0);
    check("rst_predict", predict, 0);
    check("rst_index",   index_o, 0);
    check("rst_target",  br_target_o, 0);
    check("rst_cnt",     mispredict_cnt, 0);
    look(32'h5C);
    check("index_follows_pc", index_o, 7);

    // Allocation of 0x40 (mispredicted: predicted NT)
    upd(32'h40, 1'b1, 32'h100, 1'b0); step(); idle();
    look(32'h40);
    check("alloc_hit",     hit, 1);
    check("alloc_predict", predict, 1);
    check("alloc_target",  br_target_o, 32'h100);
    check("alloc_cnt",     mispredict_cnt, 1);

    // Hysteresis: 10 -NT-> 01
    upd(32'h40, 1'b0, 32'h0, 1'b1); step(); idle(); look(32'h40);
    check("hyst_nt1_predict", predict, 0);
    check("hyst_nt1_hit",     hit, 1);
    // 01 -T-> 10 -T-> 11
    upd(32'h40, 1'b1, 32'h100, 1'b0); step(); idle(); look(32'h40);
    check("hyst_t1_predict", predict, 1);
    upd(32'h40, 1'b1, 32'h100, 1'b1); step(); idle(); look(32'h40);
    check("hyst_t2_predict", predict, 1);
    // 11 stays 11; target refreshed on taken hit
    upd(32'h40, 1'b1, 32'h180, 1'b1); step(); idle(); look(32'h40);
    check("hyst_t3_target", br_target_o, 32'h180);
    // 11 -NT-> 10 (still taken), -NT-> 01
    upd(32'h40, 1'b0, 32'h0, 1'b1); step(); idle(); look(32'h40);
    check("hyst_sat_nt1_predict", predict, 1);
    upd(32'h40, 1'b0, 32'h0, 1'b1); step(); idle(); look(32'h40);
    check("hyst_sat_nt2_predict", predict, 0);
    check("hyst_cnt", mispredict_cnt, 5);

    // Aliasing: 0x60 shares index 0 with a different tag
    upd(32'h60, 1'b1, 32'h200, 1'b0); step(); idle();
    look(32'h40);
    check("alias_old_hit", hit, 0);
    look(32'h60);
    check("alias_new_hit",     hit, 1);
    check("alias_new_predict", predict, 1);
    check("alias_new_target",  br_target_o, 32'h200);
    // Allocation counter is 10: one NT drops prediction
    upd(32'h60, 1'b0, 32'h0, 1'b1); step(); idle(); look(32'h60);
    check("alias_ctr10_predict", predict, 0);
    check("alias_cnt", mispredict_cnt, 7);

    // Not-taken update on a tag miss leaves the entry alone
    upd(32'h40, 1'b0, 32'h999, 1'b0); step(); idle();
    look(32'h60);
    check("ntmiss_hit",    hit, 1);
    check("ntmiss_target", br_target_o, 32'h200);
    look(32'h40);
    check("ntmiss_old_hit", hit, 0);
    check("ntmiss_cnt", mispredict_cnt, 7);

    // No bypass: same-cycle lookup sees pre-update contents
    upd(32'h44, 1'b1, 32'h300, 1'b1);
    look(32'h44);
    check("nobypass_hit", hit, 0);
    step(); idle(); look(32'h44);
    check("post_update_hit",    hit, 1);
    check("post_update_target", br_target_o, 32'h300);
    check("post_update_index",  index_o, 1);

    // Flush with a concurrent (mispredicted) update
    upd(32'h48, 1'b1, 32'h400, 1'b0);
    flush_btb = 1'b1;
    step(); idle();
    look(32'h44);
    check("flush_hit_idx1", hit, 0);
    check("flush_keeps_target", br_target_o, 32'h300);
    look(32'h60);
    check("flush_hit_idx0", hit, 0);
    look(32'h48);
    check("flush_upd_dropped_hit",    hit, 0);
    check("flush_upd_dropped_target", br_target_o, 32'h0);
    check("flush_cnt_counts", mispredict_cnt, 8);

    // Reset with a concurrent update: reset wins
    upd(32'h44, 1'b1, 32'h500, 1'b0);
    rst = 1'b1;
    step(); idle(); rst = 1'b0;
    look(32'h44);
    check("rst_upd_hit",    hit, 0);
    check("rst_upd_target", br_target_o, 32'h0);
    check("rst_upd_cnt",    mispredict_cnt, 0);

    // Mispredict saturation at 15 (tag-miss NT updates change no entry)
    for (int i = 0; i < 20; i++) begin
      upd(32'h4C, 1'b0, 32'h0, 1'b1);
      step();
      if (i == 13) check("sat_cnt_14", mispredict_cnt, 14);
    end
    check("sat_cnt_hold", mispredict_cnt, 15);
    look(32'h4C);
    check("sat_no_alloc", hit, 0);
    rst = 1'b1;
    step(); rst = 1'b0;
    check("sat_rst_cnt", mispredict_cnt, 0);
    step(); idle();
    check("sat_after_rst_cnt", mispredict_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
